imem_loader: RTL and testbench

//  Writer side of the instruction-memory / PC interface. Receives program bytes from
//  the debug link (UART RX, ready/valid), packs them big-endian into 32-bit words and

---
 rtl/imem_loader.sv | 167 ++++++++++++++++
 tb/tb_imem_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction-memory / PC interface. Program bytes arrive
//   from the debug link over a ready/valid handshake. They are packed big-endian
//   into 32-bit words and written to consecutive instruction-memory words,
//   starting at byte address 0. The pipeline is held while loading. Loading ends
//   when the HALT word has been written, or with an error when memory is full.
//
// Parameters
//   MAX_WORDS    instruction-memory capacity in 32-bit words (power of 2, >= 2)
//   HALT_WORD    terminator word; it is written to memory, then loading ends
//
// Ports
//   clk            system clock, all logic on posedge
//   reset          synchronous, active-high reset
//   start_load     single-cycle load request, honoured in IDLE or ERROR
//   rx_data        program byte from the debug link
//   rx_valid       rx_data is valid; upstream holds it until rx_ready
//   rx_ready       byte accepted on a cycle with rx_valid && rx_ready
//   imem_wr_en     instruction-memory write strobe, one cycle per word
//   imem_wr_addr   byte address of the write (word index * 4)
//   imem_wr_data   word being written
//   write_en       high while memory is being loaded
//   cpu_clk_en     pipeline clock enable, low while loading
//   load_done      one-cycle pulse after the HALT word has been written
//   load_error     sticky overflow flag, cleared by reset or start_load
//   words_loaded   words written in the current/last load, HALT included
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_load,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_wr_en,
    output logic [31:0] imem_wr_addr,
    output logic [31:0] imem_wr_data,
    output logic        write_en,
    output logic        cpu_clk_en,
    output logic        load_done,
    output logic        load_error,
    output logic [31:0] words_loaded
);

    localparam int                 IDX_W    = $clog2(MAX_WORDS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(MAX_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        word;
    logic [1:0]         byte_cnt;
    logic [IDX_W-1:0]   word_idx;
    logic               accept;
    logic               restart;

    assign accept  = rx_valid && rx_ready;
    assign restart = start_load && ((state == S_IDLE) || (state == S_ERROR));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore outputs.
    // NOTE: every output gets a default before the case statement, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        rx_ready   = 1'b0;
        imem_wr_en = 1'b0;
        write_en   = 1'b0;
        cpu_clk_en = 1'b1;
        load_done  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start_load) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                rx_ready   = 1'b1;
                write_en   = 1'b1;
                cpu_clk_en = 1'b0;
                if (rx_valid && (byte_cnt == 2'd3)) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                imem_wr_en = 1'b1;
                write_en   = 1'b1;
                cpu_clk_en = 1'b0;
                // HALT is checked first, so HALT in the last slot ends cleanly.
                if (imem_wr_data == HALT_WORD) begin
                    state_nxt = S_DONE;
                end else if (word_idx == LAST_IDX) begin
                    state_nxt = S_ERROR;
                end else begin
                    state_nxt = S_LOAD;
                end
            end
            S_DONE: begin
                load_done = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERROR: begin
                if (start_load) state_nxt = S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: byte packing, write address/data, counters and error flag.
    // The write address/data registers are loaded on the 4th byte, so they are
    // valid during WRITE and keep their value afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            word         <= '0;
            byte_cnt     <= '0;
            word_idx     <= '0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            words_loaded <= '0;
            load_error   <= 1'b0;
        end else begin
            if (restart) begin
                word_idx     <= '0;
                byte_cnt     <= '0;
                words_loaded <= '0;
                load_error   <= 1'b0;
            end

            if (accept) begin
                word     <= {word[23:0], rx_data};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    imem_wr_addr <= 32'(word_idx) << 2;
                    imem_wr_data <= {word[23:0], rx_data};
                end
            end

            if (state == S_WRITE) begin
                words_loaded <= 32'(word_idx) + 32'd1;
                if (state_nxt == S_LOAD) begin
                    word_idx <= word_idx + 1'b1;
                    byte_cnt <= '0;
                end
                if (state_nxt == S_ERROR) load_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed self-checking bench for imem_loader with a 4-word memory.
//   A negedge monitor logs every write strobe and load_done pulse; the stimulus
//   compares the log against hand-computed program images.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_load;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_wr_en;
    logic [31:0] imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic        write_en;
    logic        cpu_clk_en;
    logic        load_done;
    logic        load_error;
    logic [31:0] words_loaded;

    int checks   = 0;
    int failures = 0;

    imem_loader #(
        .MAX_WORDS (4),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_load   (start_load),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .write_en     (write_en),
        .cpu_clk_en   (cpu_clk_en),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    int          cyc         = 0;
    int          done_cnt    = 0;
    int          done_cyc    = 0;
    int          last_wr_cyc = 0;
    int          clk_en_bad  = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    always @(negedge clk) begin
        cyc++;
        if (imem_wr_en) begin
            wa_q.push_back(imem_wr_addr);
            wd_q.push_back(imem_wr_data);
            last_wr_cyc = cyc;
        end
        if (load_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cpu_clk_en !== ~write_en) clk_en_bad++;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [31:0] prog [0:3];

    task automatic pulse_start();
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    // Offers one byte; optional idle gap first, optionally with a start_load pulse
    // in that gap (the loader is mid-load then, so it must be ignored).
    task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
        int n;
        if (gap > 0) begin
            rx_valid = 1'b0;
            for (int k = 0; k < gap; k++) begin
                start_load = pulse && (k == 0);
                @(negedge clk);
            end
            start_load = 1'b0;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("rx_ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic load_prog(input int nw, input int gap_max, input bit pulse);
        logic [31:0] w;
        for (int i = 0; i < nw; i++) begin
            w = prog[i];
            for (int b = 0; b < 4; b++) begin
                send_byte(w[31-8*b -: 8], int'($urandom_range(0, gap_max)), pulse);
            end
        end
    endtask

    task automatic wait_end();
        int n = 0;
        while ((write_en || load_done) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("end_timeout", 32'(n >= 20), 32'd0);
    endtask

    task automatic check_image(input string tag, input int base, input int nw);
        check({tag, "_count"}, 32'(wa_q.size() - base), 32'(nw));
        for (int i = 0; i < nw; i++) begin
            check($sformatf("%s_addr%0d", tag, i), wa_q[base+i], 32'(4*i));
            check($sformatf("%s_data%0d", tag, i), wd_q[base+i], prog[i]);
        end
    endtask

    // ---------------- stimulus ----------------
    int base;
    int dbase;

    initial begin
        start_load = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        reset      = 1'b0;
        @(negedge clk);

        // 1: reset state
        do_reset(2);
        check("rst_rx_ready",     32'(rx_ready),     32'd0);
        check("rst_wr_en",        32'(imem_wr_en),   32'd0);
        check("rst_wr_addr",      imem_wr_addr,      32'd0);
        check("rst_wr_data",      imem_wr_data,      32'd0);
        check("rst_write_en",     32'(write_en),     32'd0);
        check("rst_cpu_clk_en",   32'(cpu_clk_en),   32'd1);
        check("rst_load_done",    32'(load_done),    32'd0);
        check("rst_load_error",   32'(load_error),   32'd0);
        check("rst_words_loaded", words_loaded,      32'd0);

        // 2: basic program + HALT
        prog[0] = 32'h2001_0005;
        prog[1] = 32'hFFFF_FFFF;
        base  = wa_q.size();
        dbase = done_cnt;
        pulse_start();
        check("t2_write_en",   32'(write_en),   32'd1);
        check("t2_cpu_clk_en", 32'(cpu_clk_en), 32'd0);
        load_prog(2, 0, 1'b0);
        wait_end();
        check_image("t2", base, 2);
        check("t2_done_cnt",      32'(done_cnt - dbase),        32'd1);
        check("t2_done_latency",  32'(done_cyc - last_wr_cyc),  32'd1);
        check("t2_words_loaded",  words_loaded,                 32'd2);
        check("t2_cpu_clk_en",    32'(cpu_clk_en),              32'd1);
        check("t2_load_error",    32'(load_error),              32'd0);

        // 3: overflow with four non-HALT words
        prog[0] = 32'h1122_3344;
        prog[1] = 32'h5566_7788;
        prog[2] = 32'h99AA_BBCC;
        prog[3] = 32'h0102_0304;
        base  = wa_q.size();
        dbase = done_cnt;
        pulse_start();
        load_prog(4, 0, 1'b0);
        wait_end();
        check_image("t3", base, 4);
        check("t3_load_error",    32'(load_error),        32'd1);
        check("t3_no_done",       32'(done_cnt - dbase),  32'd0);
        check("t3_words_loaded",  words_loaded,           32'd4);
        check("t3_cpu_clk_en",    32'(cpu_clk_en),        32'd1);
        // byte offered in ERROR is not consumed
        rx_data  = 8'hAB;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("t3_err_rx_ready",  32'(rx_ready),                32'd0);
        check("t3_err_no_write",  32'(wa_q.size() - base),      32'd4);
        check("t3_err_sticky",    32'(load_error),              32'd1);
        rx_valid = 1'b0;
        pulse_start();
        check("t3_err_cleared",   32'(load_error),   32'd0);
        check("t3_wl_cleared",    words_loaded,      32'd0);
        prog[0] = 32'hFFFF_FFFF;
        base = wa_q.size();
        load_prog(1, 0, 1'b0);
        wait_end();
        check_image("t3b", base, 1);

        // 4: reset mid-word discards partial word
        base = wa_q.size();
        pulse_start();
        send_byte(8'h12, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        do_reset(1);
        check("t4_cpu_clk_en",   32'(cpu_clk_en),           32'd1);
        check("t4_write_en",     32'(write_en),             32'd0);
        check("t4_no_write",     32'(wa_q.size() - base),   32'd0);
        prog[0] = 32'hAABB_CCDD;
        prog[1] = 32'hFFFF_FFFF;
        base = wa_q.size();
        pulse_start();
        load_prog(2, 0, 1'b0);
        wait_end();
        check_image("t4", base, 2);

        // 5/6: HALT in the last slot, back-to-back then with gaps and
        // stray start_load pulses; both runs must give the same image
        prog[0] = 32'hDEAD_BEEF;
        prog[1] = 32'h0000_0001;
        prog[2] = 32'h8000_0000;
        prog[3] = 32'hFFFF_FFFF;
        base  = wa_q.size();
        dbase = done_cnt;
        pulse_start();
        load_prog(4, 0, 1'b0);
        wait_end();
        check_image("t5a", base, 4);
        check("t5a_done",        32'(done_cnt - dbase),  32'd1);
        check("t5a_no_error",    32'(load_error),        32'd0);
        check("t5a_words",       words_loaded,           32'd4);

        base  = wa_q.size();
        dbase = done_cnt;
        pulse_start();
        load_prog(4, 3, 1'b1);
        wait_end();
        check_image("t5b", base, 4);
        check("t5b_done",        32'(done_cnt - dbase),  32'd1);
        check("t5b_no_error",    32'(load_error),        32'd0);
        check("t5b_words",       words_loaded,           32'd4);

        check("clk_en_vs_write_en", 32'(clk_en_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
